// File: rtl/connect_flit_pkg.sv
// rtl/connect_flit_pkg.sv - shared flit/VC/credit types and field offsets for the flit link
// Defaults for FLIT_WIDTH, FLIT_BUFFER_DEPTH, DEST_BITS and VC_BITS apply only when the build does not supply them.
// Flit layout: [FLIT_WIDTH-1] valid, [FLIT_WIDTH-2] tail, then DEST_BITS destination, then VC_BITS VC, then payload.
`timescale 1ns/1ps
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

package connect_flit_pkg;

    typedef logic [`VC_BITS-1:0]    vc_t;
    typedef logic [`FLIT_WIDTH-1:0] flit_t;

    localparam int FLIT_VALID_BIT = `FLIT_WIDTH - 1;
    localparam int FLIT_TAIL_BIT  = `FLIT_WIDTH - 2;
    localparam int FLIT_VC_LSB    = `FLIT_WIDTH - 2 - `DEST_BITS - `VC_BITS;

    typedef struct packed {
        logic valid;
        vc_t  vc;
    } credit_t;

endpackage

// File: rtl/flit_vc_fifo.sv
// rtl/flit_vc_fifo.sv - single-VC circular flit buffer
// Ports: clk_i, rst_i (async, active-high), push_i/wdata_i write side, pop_i read side,
// rdata_o head flit, count_o occupancy (0..DEPTH), full_o.
// A push while full is dropped unless a pop happens in the same cycle; the caller only pops when non-empty.
`timescale 1ns/1ps
module flit_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    // A simultaneous pop frees the slot the push needs, so a full buffer still accepts.
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_i)   rd_d = rd_q + 1'b1;
        if (push_ok && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/flit_vc_receiver.sv
// rtl/flit_vc_receiver.sv - credit-based flit link receiver with per-VC buffers and round-robin output
// Ports: CLK_NOC, RST (async, active-high); recv_putFlit_flit_in/EN_recv_putFlit flit input;
// send_getCredits registered credit {valid, vc}; deq_flit/deq_vc/deq_valid/deq_ready output port;
// overflow_err sticky drop flag.
// Optional feature macro FLIT_RX_PACKET_LOCK_EN: grant held from first popped flit of a packet until its tail pops.
`timescale 1ns/1ps
module flit_vc_receiver #(
    parameter int NUM_VCS    = 2,
    parameter int DEPTH      = `FLIT_BUFFER_DEPTH,
    parameter int FLIT_WIDTH = `FLIT_WIDTH,
    parameter int TAIL_BIT   = FLIT_WIDTH - 2,
    parameter int VC_LSB     = FLIT_WIDTH - 2 - `DEST_BITS - `VC_BITS
) (
    input  logic                  CLK_NOC,
    input  logic                  RST,
    input  logic [FLIT_WIDTH-1:0] recv_putFlit_flit_in,
    input  logic                  EN_recv_putFlit,
    output logic [`VC_BITS:0]     send_getCredits,
    output logic [FLIT_WIDTH-1:0] deq_flit,
    output logic [`VC_BITS-1:0]   deq_vc,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic                  overflow_err
);

    import connect_flit_pkg::*;

`ifdef FLIT_RX_PACKET_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  push_fire, pop_fire, release_gnt;
    vc_t                   in_vc;
    vc_t                   gnt_q, gnt_d, scan_vc;
    logic                  lock_q, lock_d;
    logic                  ovf_q, ovf_d;
    credit_t               credit_q, credit_d;
    logic [NUM_VCS-1:0]    push_v, pop_v, full_v;
    logic [CW-1:0]         cnt   [NUM_VCS];
    logic [FLIT_WIDTH-1:0] head  [NUM_VCS];

    assign push_fire = EN_recv_putFlit && recv_putFlit_flit_in[FLIT_WIDTH-1];
    assign in_vc     = recv_putFlit_flit_in[VC_LSB +: `VC_BITS];

    // Output port is a pure function of registered state.
    assign deq_vc    = gnt_q;
    assign deq_flit  = head[gnt_q];
    assign deq_valid = (cnt[gnt_q] != '0);
    assign pop_fire  = deq_valid && deq_ready;

    genvar v;
    generate
        for (v = 0; v < NUM_VCS; v++) begin : g_vc
            assign push_v[v] = push_fire && (in_vc == vc_t'(v));
            assign pop_v[v]  = pop_fire && (gnt_q == vc_t'(v));

            flit_vc_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (FLIT_WIDTH)
            ) u_fifo (
                .clk_i   (CLK_NOC),
                .rst_i   (RST),
                .push_i  (push_v[v]),
                .pop_i   (pop_v[v]),
                .wdata_i (recv_putFlit_flit_in),
                .rdata_o (head[v]),
                .count_o (cnt[v]),
                .full_o  (full_v[v])
            );
        end
    endgenerate

    // A pop releases the grant (only on a tail pop when locking); an empty granted VC
    // is abandoned unless a packet holds the lock.
    always_comb begin
        if (pop_fire) release_gnt = !LOCK_EN || deq_flit[TAIL_BIT];
        else          release_gnt = !deq_valid && !(LOCK_EN && lock_q);
    end

    always_comb begin
        lock_d = lock_q;
        if (LOCK_EN && pop_fire) lock_d = !deq_flit[TAIL_BIT];
    end

    // Walk offsets high to low so the nearest non-empty VC after gnt wins.
    always_comb begin
        gnt_d   = gnt_q;
        scan_vc = gnt_q;
        if (release_gnt) begin
            for (int i = NUM_VCS - 1; i >= 1; i--) begin
                scan_vc = gnt_q + vc_t'(i);
                if (cnt[scan_vc] != '0) gnt_d = scan_vc;
            end
        end
    end

    always_comb begin
        credit_d.valid = pop_fire;
        credit_d.vc    = pop_fire ? gnt_q : '0;
    end

    // Same-VC pop in this cycle makes room, so that case is not an overflow.
    assign ovf_d = ovf_q
                 | (push_fire && full_v[in_vc] && !(pop_fire && (gnt_q == in_vc)));

    always_ff @(posedge CLK_NOC or posedge RST) begin
        if (RST) begin
            gnt_q    <= '0;
            lock_q   <= 1'b0;
            ovf_q    <= 1'b0;
            credit_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            lock_q   <= lock_d;
            ovf_q    <= ovf_d;
            credit_q <= credit_d;
        end
    end

    assign send_getCredits = credit_q;
    assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_flit_vc_receiver.sv
// tb/tb_flit_vc_receiver.sv - directed self-checking bench for flit_vc_receiver
`timescale 1ns/1ps
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif
module tb_flit_vc_receiver;

    localparam int FW     = `FLIT_WIDTH;
    localparam int VB     = `VC_BITS;
    localparam int VC_LSB = FW - 2 - `DEST_BITS - VB;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_in;
    logic          en;
    logic [VB:0]   credits;
    logic [FW-1:0] deq_flit;
    logic [VB-1:0] deq_vc;
    logic          deq_valid;
    logic          ready;
    logic          ovf;

    int   checks = 0;
    int   errors = 0;
    logic tl;
    logic [7:0] drain_exp [4];

    flit_vc_receiver dut (
        .CLK_NOC              (clk),
        .RST                  (rst),
        .recv_putFlit_flit_in (flit_in),
        .EN_recv_putFlit      (en),
        .send_getCredits      (credits),
        .deq_flit             (deq_flit),
        .deq_vc               (deq_vc),
        .deq_valid            (deq_valid),
        .deq_ready            (ready),
        .overflow_err         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [VB-1:0] vc, input logic tail, input logic [7:0] d);
        logic [FW-1:0] f;
        f = '0;
        f[FW-1] = 1'b1;
        f[FW-2] = tail;
        f[VC_LSB +: VB] = vc;
        f[7:0] = d;
        return f;
    endfunction

    function automatic logic [VB:0] cred(input logic [VB-1:0] vc);
        return {1'b1, vc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] f);
        flit_in = f;
        en = 1'b1;
        tick();
        en = 1'b0;
        flit_in = 'x;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flit_in = '0; ready = 1'b0;
`ifdef FLIT_RX_PACKET_LOCK_EN
        tl = 1'b1;
`else
        tl = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", deq_valid, 0);
        check("rst_credit", credits, 0);
        check("rst_ovf", ovf, 0);
        check("rst_vc", deq_vc, 0);
        rst = 1'b0;
        tick();

        // push one VC0 flit and see it, then its credit
        ready = 1'b1;
        push(tl ? 16'hC0A5 : 16'h80A5);
        check("p_valid", deq_valid, 1);
        check("p_flit", deq_flit, tl ? 16'hC0A5 : 16'h80A5);
        check("p_vc", deq_vc, 0);
        check("p_no_credit_yet", credits, 0);
        tick();
        check("p_credit", credits, 2'b10);
        check("p_empty", deq_valid, 0);
        tick();
        check("p_credit_once", credits, 0);

        // fill VC1 to DEPTH
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(1, tl, 8'h10 + 8'(i)));
        check("fill_no_ovf", ovf, 0);
        check("fill_vc", deq_vc, 1);
        check("fill_head", deq_flit, mk(1, tl, 8'h10));

        // push and pop the full VC in one cycle
        ready = 1'b1;
        push(mk(1, tl, 8'h20));
        ready = 1'b0;
        check("pp_no_ovf", ovf, 0);
        check("pp_credit", credits, cred(1));
        check("pp_head", deq_flit, mk(1, tl, 8'h11));

        // one extra push overflows
        push(mk(1, tl, 8'h30));
        check("ovf_set", ovf, 1);

        // drain: exactly DEPTH flits in FIFO order, dropped flit absent
        drain_exp[0] = 8'h11; drain_exp[1] = 8'h12; drain_exp[2] = 8'h13; drain_exp[3] = 8'h20;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", deq_valid, 1);
            check("drain_flit", deq_flit, mk(1, tl, drain_exp[k]));
            tick();
            check("drain_credit", credits, cred(1));
        end
        check("drain_empty", deq_valid, 0);
        check("ovf_sticky", ovf, 1);
        ready = 1'b0;
        tick();
        check("drain_credit_clear", credits, 0);

`ifndef FLIT_RX_PACKET_LOCK_EN
        // per-flit round robin
        for (int i = 0; i < 3; i++) push(mk(0, 1'b0, 8'h40 + 8'(i)));
        for (int i = 0; i < 3; i++) push(mk(1, 1'b0, 8'h50 + 8'(i)));
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("rr_vc", deq_vc, 32'(k % 2));
            check("rr_flit", deq_flit, mk(VB'(k % 2), 1'b0, ((k % 2) != 0 ? 8'h50 : 8'h40) + 8'(k / 2)));
            tick();
            check("rr_credit", credits, cred(VB'(k % 2)));
        end
        check("rr_empty", deq_valid, 0);
        ready = 1'b0;
        tick();
`else
        // packet lock: VC0 packet tail arrives late, VC1 waits
        push(mk(0, 1'b0, 8'h60));
        push(mk(0, 1'b0, 8'h61));
        push(mk(1, 1'b1, 8'h70));
        push(mk(1, 1'b1, 8'h71));
        ready = 1'b1;
        check("lk_head", deq_flit, mk(0, 1'b0, 8'h60));
        tick();
        check("lk_credit", credits, cred(0));
        check("lk_body", deq_flit, mk(0, 1'b0, 8'h61));
        tick();
        for (int k = 0; k < 5; k++) begin
            check("lk_hold_valid", deq_valid, 0);
            check("lk_hold_vc", deq_vc, 0);
            tick();
        end
        push(mk(0, 1'b1, 8'h62));
        check("lk_tail", deq_flit, mk(0, 1'b1, 8'h62));
        tick();
        check("lk_tail_credit", credits, cred(0));
        check("lk_vc1_a", deq_flit, mk(1, 1'b1, 8'h70));
        tick();
        check("lk_vc1_b", deq_flit, mk(1, 1'b1, 8'h71));
        tick();
        check("lk_empty", deq_valid, 0);
        ready = 1'b0;
        tick();
`endif

        // reset with flits buffered and a credit pending
        for (int i = 0; i < 3; i++) push(mk(0, tl, 8'h80 + 8'(i)));
        for (int i = 0; i < 2; i++) push(mk(1, tl, 8'h90 + 8'(i)));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("mr_credit_pending", credits, cred(0));
        #2;
        rst = 1'b1;
        #1;
        check("mr_async_valid", deq_valid, 0);
        check("mr_async_credit", credits, 0);
        check("mr_async_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mr_no_stale", deq_valid, 0);
            check("mr_no_credit", credits, 0);
        end
        ready = 1'b0;
        push(mk(1, tl, 8'hA0));
        tick();
        check("mr_new_valid", deq_valid, 1);
        check("mr_new_vc", deq_vc, 1);
        check("mr_new_flit", deq_flit, mk(1, tl, 8'hA0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
